// File: rtl/dmem_ctrl.sv
// dmem_ctrl: byte-addressed data memory with valid/ready request and response
// ports. Write lanes come from access size and address, so callers never
// drive raw masks. Misaligned or illegal accesses return an error without
// touching the array. Sub-word loads are sign- or zero-extended.
//
// Parameters:
//   ADDR_W   - byte-address width; depth = 2^(ADDR_W-2) words (>= 3)
//   READ_LAT - cycles from load accept to rsp_valid (1 or 2)
//
// Ports:
//   clk, rst            - rising-edge clock, async active-high reset
//   req_valid/req_ready - request handshake (ready only when idle)
//   req_we              - 1 = store, 0 = load
//   req_addr            - byte address
//   req_size            - 00 byte, 01 half, 10 word, 11 illegal
//   req_signed          - loads: 1 = sign-extend, 0 = zero-extend
//   req_wdata           - right-aligned store data
//   rsp_valid/rsp_ready - response handshake
//   rsp_rdata           - load result (0 for stores and errors)
//   rsp_err             - access was misaligned or illegal
module dmem_ctrl #(
    parameter int ADDR_W   = 10,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int DEPTH = 1 << (ADDR_W - 2);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [31:0]       r_mem [0:DEPTH-1];
    logic [31:0]       r_rdraw;
    logic [31:0]       r_rsp_rdata;
    logic              r_rsp_err;
    logic [1:0]        r_size;
    logic              r_signed;
    logic [1:0]        r_off;

    logic [ADDR_W-3:0] w_idx;
    logic [1:0]        w_off;
    logic              w_accept;
    logic              w_err;
    logic              w_write;
    logic              w_read;
    logic [3:0]        w_wmask;
    logic [31:0]       w_wdata;
    logic [31:0]       w_src;
    logic [1:0]        w_fmt_size;
    logic [1:0]        w_fmt_off;
    logic              w_fmt_signed;
    logic [31:0]       w_fmt;

    function automatic logic [31:0] f_format(input logic [31:0] word,
                                             input logic [1:0]  size,
                                             input logic [1:0]  off,
                                             input logic        sgn);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   res = {{24{sgn & b[7]}}, b};
            2'b01:   res = {{16{sgn & h[15]}}, h};
            default: res = word;
        endcase
        return res;
    endfunction

    assign w_idx    = req_addr[ADDR_W-1:2];
    assign w_off    = req_addr[1:0];
    assign w_accept = req_valid && (r_state == ST_IDLE);

    assign req_ready = (r_state == ST_IDLE);
    assign rsp_valid = (r_state == ST_RESP);
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

    always_comb begin
        w_err   = 1'b0;
        w_wmask = '0;
        w_wdata = req_wdata;
        case (req_size)
            2'b00: begin
                w_wmask = 4'b0001 << w_off;
                w_wdata = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                w_err   = w_off[0];
                w_wmask = w_off[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{req_wdata[15:0]}};
            end
            2'b10: begin
                w_err   = (w_off != 2'b00);
                w_wmask = 4'b1111;
            end
            default: w_err = 1'b1;
        endcase
    end

    assign w_write = w_accept && req_we && !w_err;
    assign w_read  = w_accept && !req_we && !w_err;

    // With one cycle of latency the result is formatted straight from the
    // array at accept; with two it is formatted from the raw word captured
    // at accept, using the latched size/sign/offset.
    always_comb begin
        w_src        = r_mem[w_idx];
        w_fmt_size   = req_size;
        w_fmt_off    = w_off;
        w_fmt_signed = req_signed;
        if (READ_LAT == 2) begin
            w_src        = r_rdraw;
            w_fmt_size   = r_size;
            w_fmt_off    = r_off;
            w_fmt_signed = r_signed;
        end
        w_fmt = f_format(w_src, w_fmt_size, w_fmt_off, w_fmt_signed);
    end

    // Array and raw read register: never reset, contents survive rst.
    always_ff @(posedge clk) begin
        if (w_write) begin
            for (int unsigned k = 0; k < 4; k++) begin
                if (w_wmask[k]) begin
                    r_mem[w_idx][8*k +: 8] <= w_wdata[8*k +: 8];
                end
            end
        end
        if (w_read) begin
            r_rdraw <= r_mem[w_idx];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_size      <= '0;
            r_signed    <= 1'b0;
            r_off       <= '0;
        end else if (w_accept) begin
            r_size      <= req_size;
            r_signed    <= req_signed;
            r_off       <= w_off;
            r_rsp_err   <= w_err;
            r_rsp_rdata <= (w_read && READ_LAT != 2) ? w_fmt : '0;
        end else if (r_state == ST_WAIT) begin
            r_rsp_rdata <= w_fmt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next = (w_read && READ_LAT == 2) ? ST_WAIT : ST_RESP;
                end
            end
            ST_WAIT: w_next = ST_RESP;
            ST_RESP: begin
                if (rsp_ready) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
Parametrised byte-addressed data memory with a valid/ready request port and a valid/ready response port. The block generates its own byte-write lanes from access size and address, so callers do not drive raw write masks. It checks alignment, sign- or zero-extends sub-word loads, and has a configurable read latency. It sits between the core's load/store unit and on-chip data RAM, and replaces the raw mask-driven data memory.

Parameters:
ADDR_W, 10, byte-address width; depth = 2^(ADDR_W-2) 32-bit words; must be >= 3
READ_LAT, 1, cycles from read accept to rsp_valid; legal values 1 or 2

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
req_valid  in  1  request present
req_ready  out  1  block can accept a request
req_we  in  1  1 = store, 0 = load
req_addr  in  ADDR_W  byte address
req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal
req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend
req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_rdata  out  32  load result; 0 for stores and errors
rsp_err  out  1  access was misaligned or illegal

Behaviour:
- Word index = req_addr[ADDR_W-1:2]. Byte offset o = req_addr[1:0]. Lane k holds bits [8k+7:8k].
- One outstanding request at a time. FSM states:
  - IDLE: req_ready = 1.
  - WAIT: read pipeline stage; used only when READ_LAT = 2.
  - RESP: rsp_valid = 1.
  - req_ready is 0 in WAIT and RESP.
- Accept = req_valid && req_ready. On accept, latch req_we, req_size, req_signed and o.
- Error check at accept:
  - Error conditions: size 11; half with o[0] = 1; word with o != 0.
  - On error: no memory access; next state RESP; rsp_err = 1; rsp_rdata = 0.
- Store, aligned:
  - The array is written on the accept edge.
  - Byte mask: byte = 1 << o; half = 0011 when o = 0, 1100 when o = 2; word = 1111.
  - Data: req_wdata[7:0] is placed in lane o (byte); req_wdata[15:0] in lanes o/o+1 (half); full word otherwise.
  - Unmasked lanes are unchanged. Next state RESP; rsp_rdata = 0, rsp_err = 0.
- Load, aligned:
  - The array word is read synchronously on the accept edge.
  - READ_LAT = 1: next state RESP.
  - READ_LAT = 2: next state WAIT for one cycle (registered stage), then RESP.
  - Result formatting: byte = lane o; half = lanes o+1:o; word = whole word.
  - Extension: req_signed = 1 sign-extends to 32 bits; req_signed = 0 zero-extends. req_signed is ignored for word loads.
- Response timing: rsp_valid rises exactly 1 cycle after accept for stores and errors, and READ_LAT cycles after accept for loads.
- RESP: rsp_valid, rsp_rdata and rsp_err stay stable until rsp_valid && rsp_ready. On that edge: next state IDLE, rsp_valid = 0. The earliest next accept is the following cycle.
- Outputs are registered, with no combinational path from req_* to rsp_*. req_ready is decoded from state only.
- Reset (any time, including mid-WAIT or mid-RESP):
  - state = IDLE; rsp_valid = 0; rsp_rdata = 0; rsp_err = 0; req_ready = 1 once rst deasserts.
  - A store committed on its accept edge stays committed.
  - A pending load response is discarded.
  - Memory contents are not cleared by reset; the array is uninitialised after power-up.
- Simultaneous rsp handshake and req_valid: the request is not accepted that cycle, because req_ready = 0 in RESP.
- Address wrap is not possible: depth is a power of two and fully decoded.

Test Plan:
- Store word 0x00000001 @0x000, then load word @0x000 -> rsp_rdata 0x00000001, rsp_err 0; store rsp_valid exactly 1 cycle after accept.
- Store byte 0x07 @0x003, then store half 0x2345 @0x000, then load word @0x000 -> 0x07002345 (lanes 1:0 overwritten, lane 3 preserved).
- Store word 0xFEDC2345 @0x004. Load byte signed @0x007 -> 0xFFFFFFFE. Load byte unsigned @0x007 -> 0x000000FE. Load half signed @0x004 -> 0x00002345. Load half signed @0x006 -> 0xFFFFFEDC.
- Store half 0xBEEF @0x001 -> rsp_err 1, rsp_rdata 0; subsequent load word @0x000 still 0x07002345. req_size 11 -> rsp_err 1.
- Hold rsp_ready = 0 for 3 cycles during a load response -> rsp_valid/rsp_rdata held stable, req_ready 0, req_valid ignored; accept occurs only after the handshake.
- READ_LAT = 2: load @0x004 -> rsp_valid 2 cycles after accept. Assert rst in WAIT -> rsp_valid 0, req_ready 1 after release; a new load @0x004 still returns 0xFEDC2345.
